// File: rtl/fpm_pkg.sv
// ---------------------------------------------------------------------------
// fpm_pkg -- shared definitions for the FP32 multiplier scheduler.
//   FP_W / RMODE_W : operand and rounding-mode widths
//   IDX_W          : requester index width (up to 8 requesters)
//   CNT_W          : exception counter width
//   RM_*           : rounding-mode encodings forwarded to the multiplier
//   tag_t          : per-operation tag carried alongside the multiplier
// ---------------------------------------------------------------------------
package fpm_pkg;

    localparam int FP_W    = 32;
    localparam int RMODE_W = 3;
    localparam int IDX_W   = 3;
    localparam int CNT_W   = 16;

    localparam logic [RMODE_W-1:0] RM_RTZ = 3'b000;
    localparam logic [RMODE_W-1:0] RM_RMM = 3'b001;
    localparam logic [RMODE_W-1:0] RM_RDN = 3'b010;
    localparam logic [RMODE_W-1:0] RM_RUP = 3'b011;
    localparam logic [RMODE_W-1:0] RM_RNE = 3'b100;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/fpm_rr_arb.sv
// ---------------------------------------------------------------------------
// fpm_rr_arb -- combinational round-robin arbiter.
//   req     : request vector
//   ptr     : index with highest priority this cycle
//   gnt     : one-hot grant (zero when nothing requests)
//   gnt_idx : binary index of the granted requester
// Scans from ptr upward, wrapping from NUM_REQ-1 to 0.
// ---------------------------------------------------------------------------
module fpm_rr_arb
    import fpm_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    always_comb begin
        int   j;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/fpm_sched.sv
// ---------------------------------------------------------------------------
// fpm_sched -- shares one external FP32 multiplier among NUM_REQ requesters.
//
// Parameters
//   NUM_REQ : number of requesters (2..8)
//   MUL_LAT : register latency of the external multiplier (0..8)
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid / req_ready : per-requester handshake, ready is a one-hot
//                           combinational round-robin grant
//   req_x, req_y          : packed FP32 operands, requester i at [32i+31:32i]
//   req_rmode             : packed 3-bit rounding modes
//   mul_x, mul_y, mul_rmode : registered operands to the multiplier
//   mul_z, mul_ovrf, mul_udrf : multiplier result and flags
//   rsp_valid             : one-hot single-cycle result strobe
//   rsp_z, rsp_ovrf, rsp_udrf : registered result, held between strobes
//   idle                  : nothing requesting and nothing in flight
//
// Optional feature (macro FPM_SCHED_EXC_CNT_EN):
//   ovrf_cnt, udrf_cnt    : saturating counts of results with the
//                           overflow / underflow flag set
// ---------------------------------------------------------------------------
module fpm_sched
    import fpm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*FP_W-1:0]    req_x,
    input  logic [NUM_REQ*FP_W-1:0]    req_y,
    input  logic [NUM_REQ*RMODE_W-1:0] req_rmode,
    output logic [FP_W-1:0]            mul_x,
    output logic [FP_W-1:0]            mul_y,
    output logic [RMODE_W-1:0]         mul_rmode,
    input  logic [FP_W-1:0]            mul_z,
    input  logic                       mul_ovrf,
    input  logic                       mul_udrf,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [FP_W-1:0]            rsp_z,
    output logic                       rsp_ovrf,
    output logic                       rsp_udrf,
    output logic                       idle
`ifdef FPM_SCHED_EXC_CNT_EN
    ,
    output logic [CNT_W-1:0]           ovrf_cnt,
    output logic [CNT_W-1:0]           udrf_cnt
`endif
);

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               vld_p0;
    logic [FP_W-1:0]    sel_x;
    logic [FP_W-1:0]    sel_y;
    logic [RMODE_W-1:0] sel_rmode;
    logic               tag_any;

    // tag_p[0] is loaded with the operands; tag_p[MUL_LAT] lines up with mul_z
    tag_t tag_p [MUL_LAT+1];

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + IDX_W'(1);
    endfunction

    // ---- arbitration and operand select (combinational) ----
    fpm_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grant is suppressed during reset so nothing can be accepted then.
    assign req_ready = rst ? '0 : gnt;
    assign vld_p0    = |req_ready;

    assign sel_x     = req_x[int'(gnt_idx)*FP_W +: FP_W];
    assign sel_y     = req_y[int'(gnt_idx)*FP_W +: FP_W];
    assign sel_rmode = req_rmode[int'(gnt_idx)*RMODE_W +: RMODE_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (vld_p0) begin
            rr_ptr <= next_ptr(gnt_idx);
        end
    end

    // ---- issue stage: operand registers feeding the multiplier ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_x     <= '0;
            mul_y     <= '0;
            mul_rmode <= '0;
        end else if (vld_p0) begin
            mul_x     <= sel_x;
            mul_y     <= sel_y;
            mul_rmode <= sel_rmode;
        end
    end

    // ---- tag pipeline: follows each operation through the multiplier ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= MUL_LAT; k++) begin
                tag_p[k] <= '0;
            end
        end else begin
            tag_p[0].vld <= vld_p0;
            tag_p[0].idx <= gnt_idx;
            for (int k = 1; k <= MUL_LAT; k++) begin
                tag_p[k] <= tag_p[k-1];
            end
        end
    end

    always_comb begin
        tag_any = 1'b0;
        for (int k = 0; k <= MUL_LAT; k++) begin
            tag_any = tag_any | tag_p[k].vld;
        end
    end

    assign idle = ~(|req_valid) & ~tag_any;

    // ---- response stage: capture result for the tagged owner ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_z     <= '0;
            rsp_ovrf  <= 1'b0;
            rsp_udrf  <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (tag_p[MUL_LAT].vld) begin
                rsp_valid <= NUM_REQ'(1) << tag_p[MUL_LAT].idx;
                rsp_z     <= mul_z;
                rsp_ovrf  <= mul_ovrf;
                rsp_udrf  <= mul_udrf;
            end
        end
    end

`ifdef FPM_SCHED_EXC_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // ---- exception counters: sampled on the delivered response ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovrf_cnt <= '0;
            udrf_cnt <= '0;
        end else if (|rsp_valid) begin
            if (rsp_ovrf) begin
                ovrf_cnt <= sat_inc(ovrf_cnt);
            end
            if (rsp_udrf) begin
                udrf_cnt <= sat_inc(udrf_cnt);
            end
        end
    end
`endif

endmodule

// File: doc/fpm_sched.md
FPM_SCHED -- requirements
Module: fpm_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one FP32 multiplier (2..8).
REQ-002 Parameter MUL_LAT, default 2: multiplier register latency in clock edges (0..8).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  NUM_REQ  per-requester operation request.
REQ-006 req_ready  out  NUM_REQ  one-hot grant; handshake = valid & ready at the rising edge.
REQ-007 req_x, req_y  in  NUM_REQ*32 each  IEEE-754 single operands, requester i at [32i+31:32i].
REQ-008 req_rmode  in  NUM_REQ*3  per-requester rounding mode.
REQ-009 mul_x, mul_y  out  32 each  registered operands to the multiplier.
REQ-010 mul_rmode  out  3  registered rounding mode to the multiplier.
REQ-011 mul_z  in  32; mul_ovrf, mul_udrf  in  1 each  multiplier result and flags.
REQ-012 rsp_valid  out  NUM_REQ  one-hot, one-cycle result pulse to the owning requester.
REQ-013 rsp_z  out  32; rsp_ovrf, rsp_udrf  out  1 each  registered result and flags.
REQ-014 idle  out  1  high when no request pending and no operation in flight.

Function
REQ-015 The arbiter shall be round-robin: grant the lowest index i with req_valid[i] scanning from rr_ptr upward, wrapping at NUM_REQ-1 to 0.
REQ-016 req_ready shall be combinational, at most one bit set, and asserted only for a requester with req_valid high.
REQ-017 On handshake, rr_ptr shall become granted index + 1 modulo NUM_REQ; with no handshake rr_ptr holds.
REQ-018 The block shall accept at most one operation per cycle, back-to-back, with no bubbles.
REQ-019 On handshake at edge E0, mul_x/mul_y/mul_rmode shall load the granted operands at E0; with no handshake they hold.
REQ-020 A tag pipeline (valid + requester index), MUL_LAT+1 deep, shall track each issued operation.
REQ-021 mul_z/flags shall be sampled at edge E0+MUL_LAT+1; rsp_valid shall assert for exactly one cycle after that edge, one-hot at the tagged index.
REQ-022 rsp_z/rsp_ovrf/rsp_udrf shall hold their last value when rsp_valid is low.
REQ-023 Results shall be returned in issue order; there is no result backpressure.
REQ-024 A continuously requesting requester shall be granted within NUM_REQ handshakes.
REQ-025 A requester may drop req_valid without a handshake; no state changes for it.
REQ-026 idle = no req_valid bit set and no valid bit in the tag pipeline.

Reset
REQ-027 rst high shall immediately clear rr_ptr, the tag pipeline, mul_x, mul_y, mul_rmode, rsp_valid, rsp_z, rsp_ovrf, rsp_udrf and counters to 0.
REQ-028 req_ready shall be 0 while rst is high.
REQ-029 In-flight operations at reset assertion shall be discarded; no rsp_valid shall ever be produced for them.

Configuration
REQ-030 Macro FPM_SCHED_EXC_CNT_EN defined: outputs ovrf_cnt and udrf_cnt (16 bits each) shall count rsp_valid cycles with rsp_ovrf/rsp_udrf set, saturating at 16'hFFFF, cleared by rst.
REQ-031 Macro not defined: those ports and counters shall not exist; all other behaviour is identical.

Structure
REQ-032 Package fpm_pkg shall hold FP_W=32, RMODE_W=3, rounding-mode constants (RM_RNE=3'b100 etc.) and the tag struct type.
REQ-033 The round-robin arbiter shall be a sub-module fpm_rr_arb (req vector, ptr in, one-hot grant out).

Verification
REQ-034 NUM_REQ=4, MUL_LAT=2, only req 1 valid, x=0x40000000, y=0x40400000, rmode=3'b100 -> req_ready=4'b0010 same cycle, rsp_valid=4'b0010 with rsp_z=0x40C00000 exactly 3 edges later.
REQ-035 All four valid continuously for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; responses in the same order, one per cycle.
REQ-036 req 2 x=y=0x7F000000 -> rsp_z=0x7F800000, rsp_ovrf=1; with FPM_SCHED_EXC_CNT_EN, ovrf_cnt increments 0->1.
REQ-037 Three operations issued, rst pulsed one cycle after the third -> no rsp_valid for any of them, idle=1 after rst.
REQ-038 Only req 3 valid, then req 0 and 3 valid together -> rr_ptr wrap grants 0 next, then 3.
REQ-039 Bench multiplier model (MUL_LAT-stage shortreal product) compared against rsp_z for 1000 random operand pairs -> zero mismatches.
